// File: rtl/tron_pkg.sv
// ---------------------------------------------------------------------------
// tron_pkg
// Shared definitions for the light-cycle round judge: the judge state
// encoding, default match parameters and the round timer width.
// ---------------------------------------------------------------------------
package tron_pkg;

    localparam int WIN_TARGET_DEF  = 5;           // round wins that end a match
    localparam int RESOLVE_CYC_DEF = 2;           // simultaneous-crash window
    localparam int HOLD_CYC_DEF    = 50_000_000;  // pause between rounds
    localparam int TIMER_W         = 26;          // holds HOLD_CYC up to 2^26-1

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PLAY    = 3'd1,
        ST_RESOLVE = 3'd2,
        ST_REPORT  = 3'd3,
        ST_HOLD    = 3'd4,
        ST_DONE    = 3'd5
    } state_e;

endpackage

// File: rtl/cycle_timer.sv
// ---------------------------------------------------------------------------
// cycle_timer
// Loadable down-counter shared by the RESOLVE window and the HOLD pause.
// Loading N gives N further enabled cycles before done rises; the counter
// stops at zero.
//   clk      : rising-edge clock
//   clear_b  : asynchronous active-low clear
//   load     : load load_val (has priority over en)
//   load_val : value to load
//   en       : count down while non-zero
//   done     : count is zero
//   last     : count is one (next enabled cycle reaches zero)
// ---------------------------------------------------------------------------
module cycle_timer #(
    parameter int W = 26
) (
    input  logic         clk,
    input  logic         clear_b,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         done,
    output logic         last
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge clear_b) begin
        if (!clear_b) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign done = (cnt_q == '0);
    assign last = (cnt_q == W'(1));

endmodule

// File: rtl/round_judge.sv
// ---------------------------------------------------------------------------
// round_judge
// Referee for a two-player light-cycle match. Watches crash events, decides
// each round (win or draw, with a short window in which a second crash still
// counts as simultaneous), keeps per-player win counts, pauses between rounds
// and flags the end of the match. Every output is a register.
//   clk           : rising-edge clock
//   clear_b       : asynchronous active-low reset
//   start         : level, begins a match from IDLE or DONE
//   crash1/crash2 : player crashed this cycle
//   p1_won/p2_won : winner of the last round, held until next round starts
//   someone_won   : one-cycle pulse the cycle after a decided round
//   draw          : one-cycle pulse, round tied
//   round_restart : one-cycle pulse in the last pause cycle
//   playing       : round in progress
//   match_over    : a player reached WIN_TARGET
//   score_clear_b : active-low clear to external score counters
// ---------------------------------------------------------------------------
module round_judge
    import tron_pkg::*;
#(
    parameter int WIN_TARGET  = WIN_TARGET_DEF,
    parameter int RESOLVE_CYC = RESOLVE_CYC_DEF,
    parameter int HOLD_CYC    = HOLD_CYC_DEF
) (
    input  logic clk,
    input  logic clear_b,
    input  logic start,
    input  logic crash1,
    input  logic crash2,
    output logic p1_won,
    output logic p2_won,
    output logic someone_won,
    output logic draw,
    output logic round_restart,
    output logic playing,
    output logic match_over,
    output logic score_clear_b
);

    localparam logic [7:0]         WIN_T     = 8'(WIN_TARGET);
    localparam logic [TIMER_W-1:0] RES_LOAD  = TIMER_W'(RESOLVE_CYC - 1);
    localparam logic [TIMER_W-1:0] HOLD_LOAD = TIMER_W'(HOLD_CYC - 1);
    localparam logic               HOLD_ONE  = (HOLD_CYC == 1);

    state_e             state_q, state_d;
    logic               c1_q, c2_q;
    logic [7:0]         p1_cnt_q, p2_cnt_q;
    logic               tmr_load, tmr_en, tmr_done, tmr_last;
    logic [TIMER_W-1:0] tmr_val;
    logic               c1_fin, c2_fin, res_end, hold_exit;

    // Crash flags including the current cycle, used when the window closes.
    assign c1_fin    = c1_q | crash1;
    assign c2_fin    = c2_q | crash2;
    assign res_end   = (state_q == ST_RESOLVE) && tmr_done;
    assign hold_exit = (state_q == ST_HOLD) && tmr_done;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (start) state_d = ST_PLAY;
            ST_PLAY:    if (crash1 || crash2) state_d = ST_RESOLVE;
            ST_RESOLVE: if (tmr_done) state_d = ST_REPORT;
            // Counts were already bumped on REPORT entry.
            ST_REPORT:  state_d = ((p1_cnt_q == WIN_T) || (p2_cnt_q == WIN_T))
                                  ? ST_DONE : ST_HOLD;
            ST_HOLD:    if (tmr_done) state_d = ST_PLAY;
            ST_DONE:    if (start) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = '0;
        if ((state_q == ST_PLAY) && (crash1 || crash2)) begin
            tmr_load = 1'b1;
            tmr_val  = RES_LOAD;
        end else if ((state_q == ST_REPORT) && (state_d == ST_HOLD)) begin
            tmr_load = 1'b1;
            tmr_val  = HOLD_LOAD;
        end
    end

    assign tmr_en = (state_q == ST_RESOLVE) || (state_q == ST_HOLD);

    cycle_timer #(
        .W (TIMER_W)
    ) u_timer (
        .clk      (clk),
        .clear_b  (clear_b),
        .load     (tmr_load),
        .load_val (tmr_val),
        .en       (tmr_en),
        .done     (tmr_done),
        .last     (tmr_last)
    );

    always_ff @(posedge clk or negedge clear_b) begin
        if (!clear_b) begin
            state_q       <= ST_IDLE;
            c1_q          <= 1'b0;
            c2_q          <= 1'b0;
            p1_cnt_q      <= '0;
            p2_cnt_q      <= '0;
            p1_won        <= 1'b0;
            p2_won        <= 1'b0;
            someone_won   <= 1'b0;
            draw          <= 1'b0;
            round_restart <= 1'b0;
            playing       <= 1'b0;
            match_over    <= 1'b0;
            score_clear_b <= 1'b0;
        end else begin
            state_q <= state_d;

            // Crash latches: captured on the first crash, accumulated
            // through the window, dropped when a new round begins.
            if ((state_q == ST_PLAY) && (state_d == ST_RESOLVE)) begin
                c1_q <= crash1;
                c2_q <= crash2;
            end else if (state_q == ST_RESOLVE) begin
                c1_q <= c1_fin;
                c2_q <= c2_fin;
            end else if (hold_exit || (state_d == ST_IDLE)) begin
                c1_q <= 1'b0;
                c2_q <= 1'b0;
            end

            // Win counts saturate at WIN_TARGET.
            if (state_d == ST_IDLE) begin
                p1_cnt_q <= '0;
                p2_cnt_q <= '0;
            end else if (res_end) begin
                if (c2_fin && !c1_fin && (p1_cnt_q < WIN_T))
                    p1_cnt_q <= p1_cnt_q + 8'd1;
                if (c1_fin && !c2_fin && (p2_cnt_q < WIN_T))
                    p2_cnt_q <= p2_cnt_q + 8'd1;
            end

            if ((state_d == ST_IDLE) || hold_exit) begin
                p1_won <= 1'b0;
                p2_won <= 1'b0;
            end else if (res_end) begin
                p1_won <= c2_fin & ~c1_fin;
                p2_won <= c1_fin & ~c2_fin;
            end

            draw          <= res_end & c1_fin & c2_fin;
            // One cycle behind the winner flag, so never on its rising edge.
            someone_won   <= (state_q == ST_REPORT) & (p1_won | p2_won);
            round_restart <= ((state_q == ST_HOLD) && tmr_last)
                          || ((state_q == ST_REPORT) && (state_d == ST_HOLD) && HOLD_ONE);
            playing       <= (state_d == ST_PLAY);
            match_over    <= (state_d == ST_DONE);
            score_clear_b <= (state_d != ST_IDLE);
        end
    end

endmodule

// File: doc/round_judge.md
ROUND_JUDGE -- requirements
Module: round_judge

Interface
REQ-001 SHALL have parameter WIN_TARGET, default 5, round wins that end a match (legal 1..255).
REQ-002 SHALL have parameter RESOLVE_CYC, default 2, extra cycles after first crash during which a second crash still counts as simultaneous (legal 1..255).
REQ-003 SHALL have parameter HOLD_CYC, default 50_000_000, pause cycles between rounds (legal 1..2^26-1).
REQ-004 SHALL have port clk  input  1  single rising-edge clock.
REQ-005 SHALL have port clear_b  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port start  input  1  level; begins a match from IDLE or DONE.
REQ-007 SHALL have port crash1  input  1  player 1 crashed this cycle.
REQ-008 SHALL have port crash2  input  1  player 2 crashed this cycle.
REQ-009 SHALL have port p1_won  output  1  player 1 took the last round.
REQ-010 SHALL have port p2_won  output  1  player 2 took the last round.
REQ-011 SHALL have port someone_won  output  1  one-cycle win event, drives score counter clock.
REQ-012 SHALL have port draw  output  1  one-cycle pulse, round tied.
REQ-013 SHALL have port round_restart  output  1  one-cycle pulse, game logic re-seeds arena.
REQ-014 SHALL have port playing  output  1  round in progress.
REQ-015 SHALL have port match_over  output  1  a player reached WIN_TARGET.
REQ-016 SHALL have port score_clear_b  output  1  active-low clear to score counters.

Function
REQ-017 SHALL implement states IDLE, PLAY, RESOLVE, REPORT, HOLD, DONE; all outputs registered.
REQ-018 IDLE: score_clear_b=0, win counts held 0; start=1 -> PLAY next cycle.
REQ-019 PLAY: playing=1; crash1|crash2 -> RESOLVE, latching c1/c2 from that cycle.
REQ-020 RESOLVE: lasts exactly RESOLVE_CYC cycles; c1|=crash1, c2|=crash2 each cycle; then -> REPORT.
REQ-021 REPORT (one cycle): c1 only -> p2_won=1; c2 only -> p1_won=1; both -> draw=1, neither pN_won set, no count change; winner's 8-bit count increments.
REQ-022 someone_won SHALL pulse high exactly one cycle, the cycle after REPORT, never coincident with the rising edge of p1_won/p2_won.
REQ-023 p1_won/p2_won SHALL stay stable from REPORT until next PLAY entry or IDLE; never both 1.
REQ-024 After REPORT: incremented count == WIN_TARGET -> DONE, else -> HOLD.
REQ-025 HOLD: lasts HOLD_CYC cycles; round_restart=1 in its last cycle; then -> PLAY, pN_won cleared, c1/c2 cleared.
REQ-026 DONE: match_over=1; start=1 -> IDLE (one cycle, scores cleared) then PLAY if start still 1.
REQ-027 crash1/crash2 SHALL be ignored in IDLE, REPORT, HOLD, DONE; start ignored outside IDLE/DONE.
REQ-028 Win counts SHALL never exceed WIN_TARGET; no wrap.

Reset
REQ-029 clear_b=0 SHALL force IDLE, counts/timers/latches 0, all outputs 0 except score_clear_b=0, asynchronously, including mid-RESOLVE or mid-HOLD.
REQ-030 Release SHALL take effect on first clk edge with clear_b=1; no pulse output fires during reset release.

Structure
REQ-031 Shared package tron_pkg SHALL hold the state enum and default WIN_TARGET/RESOLVE_CYC/HOLD_CYC constants.
REQ-032 SHALL instantiate one sub-module cycle_timer (loadable down-counter, done flag) reused for RESOLVE and HOLD.

Verification (WIN_TARGET=3, RESOLVE_CYC=2, HOLD_CYC=4)
REQ-033 Reset then start=1 one cycle -> score_clear_b 0 until PLAY, playing=1 next cycle.
REQ-034 crash1 pulse in PLAY -> after 2 RESOLVE cycles p2_won=1, someone_won pulse 1 cycle later, round_restart after 4 HOLD cycles.
REQ-035 crash2 then crash1 one cycle later -> draw pulse, someone_won stays 0, counts unchanged.
REQ-036 crash1 and crash2 same cycle three rounds vs crash2 three rounds -> p1 reaches 3, match_over=1, no round_restart.
REQ-037 clear_b low mid-HOLD -> immediate IDLE, all outputs 0, score_clear_b 0, no someone_won.
REQ-038 crash1 held high through HOLD -> ignored; exactly one win counted per round.
